// File: rtl/fetch_stage_if.sv
`default_nettype none
//==============================================================================
// fetch_stage_if -- instruction-memory req/ack bus between IF stage and imem. Rev 1.0
//==============================================================================
interface fetch_stage_if #(
  parameter int XLEN = 64
);
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemAck;
  logic [31:0]     imemData;

  modport master (output imemReq, output imemAddr, input imemAck, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
//==============================================================================
// fetch_stage -- RV64 IF stage: owns the PC, fetches over req/ack, fills IF/ID. Rev 1.0
//==============================================================================
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h00000013
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [1:0]      pcSel,
  input  wire logic            pcStall,
  input  wire logic            ifidStall,
  input  wire logic            instNop,
  input  wire logic [XLEN-1:0] branchTarget,
  input  wire logic [XLEN-1:0] jalTarget,
  input  wire logic [XLEN-1:0] jalrTarget,
  fetch_stage_if.master        imem,
  output logic [XLEN-1:0]      pc,
  output logic [31:0]          ifidInst,
  output logic [XLEN-1:0]      ifidPc,
  output logic                 ifidValid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            discard_q, discard_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;

  logic            w_stall;
  logic            w_redirect;
  logic            w_bubble;
  logic [XLEN-1:0] w_target;

  assign w_stall    = pcStall | ifidStall;
  assign w_redirect = (pcSel != 2'd0) & ~pcStall;

  always_comb begin
    unique case (pcSel)
      2'd1:    w_target = branchTarget;
      2'd2:    w_target = jalTarget;
      2'd3:    w_target = {jalrTarget[XLEN-1:1], 1'b0};
      default: w_target = branchTarget;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    pend_target_d = pend_target_q;
    discard_d     = discard_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    w_bubble      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (!imem.imemAck) begin
          w_bubble = 1'b1;
          // Remember where to go once the in-flight request finally returns.
          if (w_redirect) begin
            pend_target_d = w_target;
            discard_d     = 1'b1;
          end
        end else if (discard_q) begin
          w_bubble   = 1'b1;
          discard_d  = 1'b0;
          req_addr_d = w_redirect ? w_target : pend_target_q;
        end else if (w_redirect) begin
          w_bubble   = 1'b1;
          req_addr_d = w_target;
        end else if (w_stall) begin
          hold_inst_d = imem.imemData;
          hold_pc_d   = req_addr_q;
          req_addr_d  = req_addr_q + c_pc_step;
          state_d     = S_HOLD;
        end else begin
          ifid_inst_d  = instNop ? NOP_INST : imem.imemData;
          ifid_pc_d    = req_addr_q;
          ifid_valid_d = ~instNop;
          req_addr_d   = req_addr_q + c_pc_step;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          w_bubble   = 1'b1;
          req_addr_d = w_target;
          state_d    = S_FETCH;
        end else if (!w_stall) begin
          ifid_inst_d  = instNop ? NOP_INST : hold_inst_q;
          ifid_pc_d    = hold_pc_q;
          ifid_valid_d = ~instNop;
          state_d      = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A held IF/ID register swallows the bubble along with everything else.
    if (w_bubble && !ifidStall) begin
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_addr_q    <= RESET_PC;
      pend_target_q <= '0;
      discard_q     <= 1'b0;
      hold_inst_q   <= NOP_INST;
      hold_pc_q     <= '0;
      ifid_inst_q   <= NOP_INST;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      pend_target_q <= pend_target_d;
      discard_q     <= discard_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
    end
  end

  assign imem.imemReq  = (state_q == S_FETCH);
  assign imem.imemAddr = req_addr_q;
  assign pc            = req_addr_q;
  assign ifidInst      = ifid_inst_q;
  assign ifidPc        = ifid_pc_q;
  assign ifidValid     = ifid_valid_q;

endmodule
`default_nettype wire
